// File: rtl/seq_div_8by4.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and goes straight to DONE.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for an operand pair
// BUSY   | one restoring step per cycle, DW cycles total
// DONE   | out_valid=1, result held until out_ready
module seq_div_8by4 #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DW - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [VW:0]   prem_q, prem_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          zero_q, zero_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          dz_q, dz_d;

   logic [VW:0]   shift;
   logic [VW+1:0] trial;
   logic          qbit;
   logic [VW:0]   prem_step;
   logic [DW-1:0] quo_step;

   // Dividend bits are consumed MSB first by indexing with the down-counter,
   // so dvd_q keeps the original value for the zero-divisor remainder.
   assign shift     = {prem_q[VW-1:0], dvd_q[cnt_q]};
   assign trial     = {1'b0, shift} - {2'b00, dvs_q};
   assign qbit      = ~trial[VW+1];
   assign prem_step = qbit ? trial[VW:0] : shift;
   assign quo_step  = {quo_q[DW-2:0], qbit};

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dvd_d  = dividend;
               dvs_d  = divisor;
               prem_d = '0;
               quo_d  = '0;
               cnt_d  = CNT_LOAD;
               zero_d = (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
               if (divisor == '0) begin
                  state_d = S_DONE;
                  quot_d  = '1;
                  rem_d   = dividend[VW-1:0];
                  dz_d    = 1'b1;
               end else begin
                  state_d = S_BUSY;
               end
`else
               state_d = S_BUSY;
`endif
            end
         end
         S_BUSY: begin
            prem_d = prem_step;
            quo_d  = quo_step;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               cnt_d   = '0;
               if (zero_q) begin
                  quot_d = '1;
                  rem_d  = dvd_q[VW-1:0];
                  dz_d   = 1'b1;
               end else begin
                  quot_d = quo_step;
                  rem_d  = prem_step[VW-1:0];
                  dz_d   = 1'b0;
               end
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule
